// File: rtl/parity_serial_tx_if.sv
// Handshake and serial-line bundle for parity_serial_tx.
//   master : word producer side (drives in_valid/in_data/odd_mode,
//            observes in_ready and the serial/status outputs)
//   slave  : the transmitter itself
// Signals:
//   in_valid  producer has a word
//   in_data   word to send (DATA_W bits)
//   odd_mode  parity sense for the offered word (1 = odd, 0 = even)
//   in_ready  transmitter can accept a word this cycle
//   ser_out   serial bit, LSB first, parity bit last
//   ser_valid ser_out carries a frame bit
//   ser_last  current bit is the parity bit
//   busy      frame in progress
//   frame_cnt completed frames, wraps modulo 2^CNT_W
interface parity_serial_tx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              odd_mode;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_last;
  logic              busy;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output in_valid, in_data, odd_mode,
    input  in_ready, ser_out, ser_valid, ser_last, busy, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, odd_mode,
    output in_ready, ser_out, ser_valid, ser_last, busy, frame_cnt
  );
endinterface

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter with per-word even/odd parity.
// Accepts a parallel word over a valid/ready handshake, shifts it out
// LSB-first one bit per clock, then appends one parity bit. A new word
// can be accepted during the parity cycle so frames run gapless.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   tx_if  parity_serial_tx_if.slave (handshake, serial line, status)
// Every output is decoded from registers only.
module parity_serial_tx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  parity_serial_tx_if.slave   tx_if
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_e;

  localparam int              BCW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [BCW-1:0]    bitcnt_q;
  logic              acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              en_q;
  logic              ready;
  logic              accept;

  // en_q holds in_ready low while reset is asserted and for the first
  // edge after release, keeping in_ready a pure register decode.
  assign ready  = en_q && (state_q != DATA);
  assign accept = tx_if.in_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      en_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q  <= tx_if.in_data;
            bitcnt_q <= '0;
            acc_q    <= tx_if.odd_mode;
            state_q  <= DATA;
          end
        end
        DATA: begin
          // Seeding acc with odd_mode makes the final value the odd
          // parity bit directly, or the plain XOR for even parity.
          acc_q    <= acc_q ^ shreg_q[0];
          shreg_q  <= shreg_q >> 1;
          bitcnt_q <= bitcnt_q + BCW'(1);
          if (bitcnt_q == LAST_BIT) begin
            state_q <= PARITY;
          end
        end
        PARITY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (accept) begin
            shreg_q  <= tx_if.in_data;
            bitcnt_q <= '0;
            acc_q    <= tx_if.odd_mode;
            state_q  <= DATA;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_if.in_ready  = ready;
  assign tx_if.ser_out   = (state_q == DATA)   ? shreg_q[0] :
                           (state_q == PARITY) ? acc_q      : 1'b0;
  assign tx_if.ser_valid = (state_q != IDLE);
  assign tx_if.ser_last  = (state_q == PARITY);
  assign tx_if.busy      = (state_q != IDLE);
  assign tx_if.frame_cnt = cnt_q;

endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
- Frame controller that sequences a parity generator over a serial link.
- Accepts parallel words over a valid/ready handshake and shifts them out LSB-first, one bit per clock.
- Appends one parity bit per word, even or odd, selected per word.
- Sits between a word producer and a serial line; the downstream receiver uses the existing odd/even parity checkers.

Parameters:
- DATA_W, 8: payload bits per frame; legal range >= 1.
- CNT_W, 8: width of the frames-sent counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_data  input  DATA_W  word to send.
- odd_mode  input  1  parity sense for this word: 1 = odd parity, 0 = even parity. Sampled with in_data.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- ser_last  output  1  current bit is the parity bit (last bit of frame).
- busy  output  1  frame in progress (state != IDLE).
- frame_cnt  output  CNT_W  count of completed frames.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; shift register, bit counter and parity accumulator cleared.
  - Outputs: ser_out=0, ser_valid=0, ser_last=0, busy=0, frame_cnt=0, in_ready=0 while rst_n is low.
- All outputs are derived from registers only; there is no combinational path from any input to any output.
- States: IDLE, DATA, PARITY.
- Handshake:
  - Accept occurs on a rising edge where in_valid && in_ready.
  - in_ready = 1 in IDLE and PARITY; 0 in DATA.
  - in_data and odd_mode are don't-care when not accepted.
- On accept:
  - shreg <= in_data; bitcnt <= 0; acc <= odd_mode; state <= DATA.
- DATA state:
  - ser_out = shreg[0]; ser_valid = 1; ser_last = 0.
  - Each clock: acc <= acc ^ shreg[0]; shreg shifts right; bitcnt++.
  - On the cycle with bitcnt == DATA_W-1, next state is PARITY.
- PARITY state:
  - ser_out = acc; ser_valid = 1; ser_last = 1.
  - Resulting parity bit: even parity gives XOR of data bits; odd parity gives its inverse.
  - On exit: frame_cnt <= frame_cnt + 1, wrapping modulo 2^CNT_W with no saturation.
  - Next state is DATA if a word is accepted in this cycle, otherwise IDLE.
- Latency:
  - The first data bit appears in the cycle after the accept edge.
  - A frame occupies exactly DATA_W+1 consecutive cycles.
  - With in_valid held high, frames are gapless: throughput is one word per DATA_W+1 cycles.
- IDLE outputs: ser_out=0, ser_valid=0, ser_last=0, busy=0.
- Boundary conditions:
  - DATA_W=1: DATA lasts one cycle, then PARITY.
  - Input changes during DATA are ignored; odd_mode is latched per word.
  - Reset mid-frame aborts immediately. No partial parity bit is emitted, frame_cnt returns to 0, and the frame is not counted.
  - Counter wrap and accept in PARITY on the same edge: both take effect.

Test Plan:
1. DATA_W=8, even: accept 8'hA5 with odd_mode=0 -> ser_out over 9 cycles = 1,0,1,0,0,1,0,1 then 0. ser_last high only on the 9th cycle; frame_cnt 0->1.
2. Odd mode: accept 8'hA5 with odd_mode=1 -> same 8 data bits, parity bit 1. Accept 8'h07 with odd_mode=1 -> parity 0; with odd_mode=0 -> parity 1.
3. Back-to-back: in_valid held high with words 8'hFF (even) then 8'h01 (odd). Required response:
   - 18 contiguous cycles with ser_valid=1.
   - Parity bits 0 then 0.
   - in_ready high only in the two PARITY cycles (plus the initial IDLE cycle).
4. Stall/hold: in_valid pulsed during DATA with different data -> no accept, in_ready=0, the in-flight frame is unchanged. IDLE with in_valid=0 -> ser_valid=0, busy=0.
5. Reset mid-frame: deassert rst_n after the 3rd data bit of 8'h3C -> ser_valid, busy and frame_cnt go to 0 asynchronously (before the next edge). After release, a new 8'h00 even frame emits 9 zeros with parity 0.
6. Wrap: CNT_W=2, send 5 frames -> frame_cnt sequence 1,2,3,0,1. Also DATA_W=1: 1'b1 even gives bits 1,1; odd gives bits 1,0.
